display_resto_scan: RTL and testbench
=====================================

DISPLAY_RESTO_SCAN -- requirements
Module: display_resto_scan

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: operand/result width in bits, a multiple of 4, at least 4.
REQ-002 The block SHALL take parameter SEL_W, default 3: operation selector width.
REQ-003 The block SHALL take parameter OP_RESTO, default 3'b011: the selector code for division.
REQ-004 The block SHALL take parameter SCAN_DIV, default 50000: clock cycles per digit-scan step, at least 2.
REQ-005 The block SHALL take parameter PAGE_DIV, default 25000000: clock cycles per quotient/remainder page, at least SCAN_DIV.
REQ-006 The block SHALL derive localparam N_DIG = WIDTH/4, the hex digit count.
REQ-007 The block SHALL have the following ports (name, direction, width, meaning):
- CLK  in  1  the single clock
- RST  in  1  asynchronous, active-high reset
- SEL  in  SEL_W  operation selector
- LOAD  in  1  one-cycle pulse; result inputs are valid
- CLEAR  in  1  blanks the display
- QUOC  in  WIDTH  result/quotient
- RESTO_VAL  in  WIDTH  division remainder
- RESTO  in  1  nonzero-remainder flag
- DIG_EN  out  N_DIG  digit enables, active-low, one-hot-low
- NIBBLE  out  4  hex value for the enabled digit
- LED_RESTO  out  1  remainder-display mode active
- PAGE  out  1  0 = quotient shown, 1 = remainder shown

Function
REQ-010 The FSM SHALL have three states: IDLE (blank), SHOW_Q, SHOW_R.
REQ-011 A sampled LOAD SHALL capture QUOC, RESTO_VAL, and an alt bit; alt = (SEL==OP_RESTO) AND RESTO.
REQ-012 A sampled LOAD SHALL force SHOW_Q and clear the page counter, from any state.
REQ-013 In SHOW_Q with alt=1, the FSM SHALL move to SHOW_R when the page counter reaches PAGE_DIV-1. The counter SHALL wrap to 0 and the FSM SHALL alternate SHOW_Q/SHOW_R indefinitely.
REQ-014 In SHOW_Q with alt=0, the FSM SHALL remain in SHOW_Q, and the page counter SHALL hold at 0.
REQ-015 A sampled CLEAR SHALL force IDLE. CLEAR SHALL win over a simultaneous LOAD. The captured registers SHALL be retained but not displayed.
REQ-016 The scan counter SHALL free-run in every state. The digit index SHALL advance once per SCAN_DIV cycles, wrap from N_DIG-1 to 0, and be unaffected by LOAD or CLEAR.
REQ-017 Digit index i SHALL display nibble i (bits 4i+3:4i) of the captured QUOC in SHOW_Q, or of the captured RESTO_VAL in SHOW_R.
REQ-018 In IDLE, DIG_EN SHALL be all ones and NIBBLE SHALL be 0.
REQ-019 LED_RESTO SHALL equal alt in SHOW_Q/SHOW_R and SHALL be 0 in IDLE.
REQ-020 PAGE SHALL be 1 only in SHOW_R.
REQ-021 All outputs SHALL be registered. Outputs SHALL reflect state, index and captured data one cycle after they change, so LOAD sampled at edge k is visible at edge k+1.
REQ-022 SEL and RESTO changes without LOAD SHALL have no effect.

Reset
REQ-030 RST SHALL act immediately, without waiting for CLK.
REQ-031 On reset the state SHALL be IDLE; the scan counter, page counter, digit index, captured registers and alt SHALL be 0; DIG_EN SHALL be all ones; NIBBLE, LED_RESTO and PAGE SHALL be 0.
REQ-032 Reset asserted mid-alternation SHALL abandon the alternation; no state survives.

Structure
REQ-040 The state encodings (IDLE=2'd0, SHOW_Q=2'd1, SHOW_R=2'd2) and the OP_RESTO default SHALL live in the shared package display_pkg.
REQ-041 The SCAN_DIV and PAGE_DIV dividers SHALL each be an instance of sub-module tick_gen, parameter DIV. tick_gen SHALL have a synchronous clear input and a one-cycle tick output.
REQ-042 The implementation SHALL contain no combinational path from inputs to outputs.

Verification (WIDTH=8, SCAN_DIV=4, PAGE_DIV=32)
REQ-050 Assert RST for 3 cycles mid-simulation -> DIG_EN=2'b11, NIBBLE=0, LED_RESTO=0, PAGE=0, immediately and held.
REQ-051 LOAD with SEL=011, QUOC=8'h3A, RESTO_VAL=8'h05, RESTO=1 -> LED_RESTO=1; DIG_EN 2'b10/NIBBLE=A alternating with 2'b01/NIBBLE=3 every 4 cycles; after 32 cycles PAGE=1 with digits 5,0; PAGE returns to 0 after a further 32.
REQ-052 LOAD with SEL=011, RESTO=0 -> LED_RESTO=0; PAGE stays 0 for 200 cycles.
REQ-053 LOAD with SEL=001, QUOC=8'hFF, RESTO=1 -> LED_RESTO=0; digits F,F; PAGE never 1.
REQ-054 LOAD and CLEAR in the same cycle during SHOW_R -> IDLE next cycle: DIG_EN=2'b11, PAGE=0, LED_RESTO=0.
REQ-055 New LOAD during SHOW_R (QUOC=8'h12) -> PAGE=0 one cycle later, digits 2,1, and the page counter restarts a full 32 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the result display: FSM state encodings and
// the default selector code that identifies a division result.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_Q = 2'd1,
    SHOW_R = 2'd2
  } state_t;

  localparam logic [2:0] OP_RESTO_DEF = 3'b011;

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV cycle counter producing a one-cycle tick on the last count.
// clr restarts the count at 0 synchronously; en gates counting.
module tick_gen
  import display_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_p0;
  logic          at_end;

  assign at_end = (cnt_p0 == CW'(DIV - 1));
  assign tick   = en && at_end && !clr;

  // Count 0..DIV-1 while enabled; clear takes priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (en) begin
      cnt_p0 <= at_end ? '0 : cnt_p0 + CW'(1);
    end
  end

endmodule

// File: rtl/display_resto_scan.sv
// Multiplexed hex display of an arithmetic result. A division with a
// nonzero remainder alternates between a quotient page and a remainder
// page; every other result shows only the quotient. Digits are scanned
// one at a time with active-low enables.
module display_resto_scan
  import display_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter int              SEL_W    = 3,
  parameter logic [SEL_W-1:0] OP_RESTO = SEL_W'(OP_RESTO_DEF),
  parameter int              SCAN_DIV = 50000,
  parameter int              PAGE_DIV = 25000000,
  localparam int             N_DIG    = WIDTH / 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SEL_W-1:0] SEL,
  input  logic             LOAD,
  input  logic             CLEAR,
  input  logic [WIDTH-1:0] QUOC,
  input  logic [WIDTH-1:0] RESTO_VAL,
  input  logic             RESTO,
  output logic [N_DIG-1:0] DIG_EN,
  output logic [3:0]       NIBBLE,
  output logic             LED_RESTO,
  output logic             PAGE
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  function automatic logic [3:0] pick_nibble(input logic [WIDTH-1:0] v,
                                             input logic [IDX_W-1:0] i);
    return v[i*4 +: 4];
  endfunction

  state_t             state_p0;
  state_t             state_d;
  logic [WIDTH-1:0]   quoc_p0;
  logic [WIDTH-1:0]   resto_p0;
  logic               alt_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic               load_s;
  logic               page_run;
  logic               page_clr;
  logic               scan_tick;
  logic               page_tick;

  logic [N_DIG-1:0]   dig_en_d;
  logic [3:0]         nibble_d;
  logic               led_d;
  logic               page_d;
  logic [N_DIG-1:0]   dig_en_p1;
  logic [3:0]         nibble_p1;
  logic               led_p1;
  logic               page_p1;

  // CLEAR beats a simultaneous LOAD, so such a load captures nothing.
  assign load_s   = LOAD && !CLEAR;
  // The page timer only runs while an alternating result is on screen.
  assign page_run = alt_p0 && (state_p0 != IDLE);
  assign page_clr = LOAD || CLEAR || !page_run;

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk  (CLK),
    .rst  (RST),
    .clr  (1'b0),
    .en   (1'b1),
    .tick (scan_tick)
  );

  tick_gen #(.DIV(PAGE_DIV)) u_page (
    .clk  (CLK),
    .rst  (RST),
    .clr  (page_clr),
    .en   (page_run),
    .tick (page_tick)
  );

  // ---- stage p0: captured result, FSM state, digit index ----

  // Latch the result and decide whether it needs a remainder page.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      quoc_p0  <= '0;
      resto_p0 <= '0;
      alt_p0   <= 1'b0;
    end else if (load_s) begin
      quoc_p0  <= QUOC;
      resto_p0 <= RESTO_VAL;
      alt_p0   <= (SEL == OP_RESTO) && RESTO;
    end
  end

  // Free-running digit index, independent of LOAD and CLEAR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_p0 <= '0;
    end else if (scan_tick) begin
      idx_p0 <= (idx_p0 == IDX_W'(N_DIG - 1)) ? '0 : idx_p0 + IDX_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_d;
    end
  end

  // Next state: CLEAR, then LOAD, then page flips on the page tick.
  always_comb begin
    state_d = state_p0;
    if (CLEAR) begin
      state_d = IDLE;
    end else if (LOAD) begin
      state_d = SHOW_Q;
    end else begin
      case (state_p0)
        IDLE:    state_d = IDLE;
        SHOW_Q:  if (page_tick) state_d = SHOW_R;
        SHOW_R:  if (page_tick) state_d = SHOW_Q;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from state, index and captured data.
  always_comb begin
    dig_en_d = '1;
    nibble_d = 4'h0;
    led_d    = 1'b0;
    page_d   = 1'b0;
    case (state_p0)
      SHOW_Q: begin
        dig_en_d = ~(N_DIG'(1) << idx_p0);
        nibble_d = pick_nibble(quoc_p0, idx_p0);
        led_d    = alt_p0;
      end
      SHOW_R: begin
        dig_en_d = ~(N_DIG'(1) << idx_p0);
        nibble_d = pick_nibble(resto_p0, idx_p0);
        led_d    = alt_p0;
        page_d   = 1'b1;
      end
      default: begin
        dig_en_d = '1;
        nibble_d = 4'h0;
        led_d    = 1'b0;
        page_d   = 1'b0;
      end
    endcase
  end

  // ---- stage p1: registered outputs ----

  // Register every output so nothing combinational reaches the pins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dig_en_p1 <= '1;
      nibble_p1 <= 4'h0;
      led_p1    <= 1'b0;
      page_p1   <= 1'b0;
    end else begin
      dig_en_p1 <= dig_en_d;
      nibble_p1 <= nibble_d;
      led_p1    <= led_d;
      page_p1   <= page_d;
    end
  end

  assign DIG_EN    = dig_en_p1;
  assign NIBBLE    = nibble_p1;
  assign LED_RESTO = led_p1;
  assign PAGE      = page_p1;

endmodule

// File: tb/tb_display_resto_scan.sv
// Directed bench for display_resto_scan with fast dividers
// (WIDTH=8, SCAN_DIV=4, PAGE_DIV=32).
module tb_display_resto_scan;

  logic       CLK;
  logic       RST;
  logic [2:0] SEL;
  logic       LOAD;
  logic       CLEAR;
  logic [7:0] QUOC;
  logic [7:0] RESTO_VAL;
  logic       RESTO;
  logic [1:0] DIG_EN;
  logic [3:0] NIBBLE;
  logic       LED_RESTO;
  logic       PAGE;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  display_resto_scan #(
    .WIDTH    (8),
    .SEL_W    (3),
    .OP_RESTO (3'b011),
    .SCAN_DIV (4),
    .PAGE_DIV (32)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SEL       (SEL),
    .LOAD      (LOAD),
    .CLEAR     (CLEAR),
    .QUOC      (QUOC),
    .RESTO_VAL (RESTO_VAL),
    .RESTO     (RESTO),
    .DIG_EN    (DIG_EN),
    .NIBBLE    (NIBBLE),
    .LED_RESTO (LED_RESTO),
    .PAGE      (PAGE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edges since reset release; digit index at edge n is (n/4)%2.
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected {DIG_EN, NIBBLE, LED_RESTO, PAGE} sampled after edge n.
  function automatic logic [7:0] exp_out(input int n, input logic [7:0] data,
                                         input logic led, input logic pg,
                                         input logic blank);
    int idx;
    logic [1:0] dg;
    logic [3:0] nb;
    if (blank) return 8'b11_0000_0_0;
    idx = ((n - 1) / 4) % 2;
    dg  = (idx == 1) ? 2'b01 : 2'b10;
    nb  = (idx == 1) ? data[7:4] : data[3:0];
    return {dg, nb, led, pg};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [2:0] s, input logic [7:0] q,
                         input logic [7:0] r, input logic f);
    SEL = s; QUOC = q; RESTO_VAL = r; RESTO = f; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    RST = 1'b0; LOAD = 0; CLEAR = 0; SEL = 0; QUOC = 0; RESTO_VAL = 0; RESTO = 0;
    #1 RST = 1'b1;
    #1;
    obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
    n_cmp++;
    if (obs !== 8'b11_0000_0_0) begin
      n_bad++;
      $display("FAIL reset_immediate got=%b exp=%b", obs, 8'b11_0000_0_0);
    end
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== 8'b11_0000_0_0) begin
        n_bad++;
        $display("FAIL reset_idle j=%0d got=%b exp=%b", j, obs, 8'b11_0000_0_0);
      end
    end
  endtask

  task automatic test_alternate();
    logic [7:0] obs, ex;
    logic pg;
    do_load(3'b011, 8'h3A, 8'h05, 1'b1);
    for (int j = 1; j <= 70; j++) begin
      step();
      pg  = (j >= 33 && j <= 64);
      ex  = exp_out(cyc, pg ? 8'h05 : 8'h3A, 1'b1, pg, 1'b0);
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL alternate j=%0d got=%b exp=%b", j, obs, ex);
      end
    end
  endtask

  task automatic test_no_remainder();
    logic [7:0] obs, ex;
    do_load(3'b011, 8'hC4, 8'h99, 1'b0);
    for (int j = 1; j <= 200; j++) begin
      step();
      ex  = exp_out(cyc, 8'hC4, 1'b0, 1'b0, 1'b0);
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL no_remainder j=%0d got=%b exp=%b", j, obs, ex);
      end
    end
  endtask

  task automatic test_other_op();
    logic [7:0] obs, ex;
    do_load(3'b001, 8'hFF, 8'h77, 1'b1);
    for (int j = 1; j <= 100; j++) begin
      step();
      ex  = exp_out(cyc, 8'hFF, 1'b0, 1'b0, 1'b0);
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL other_op j=%0d got=%b exp=%b", j, obs, ex);
      end
      // selector/flag changes without LOAD must not matter
      if (j == 50) begin
        SEL = 3'b011; RESTO = 1'b1; QUOC = 8'h11; RESTO_VAL = 8'h22;
      end
    end
  endtask

  task automatic test_clear_vs_load();
    logic [7:0] obs, ex;
    logic pg;
    do_load(3'b011, 8'h3A, 8'h05, 1'b1);
    for (int j = 1; j <= 52; j++) begin
      step();
      pg  = (j >= 33);
      ex  = exp_out(cyc, pg ? 8'h05 : 8'h3A, 1'b1, pg, j >= 42);
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL clear_vs_load j=%0d got=%b exp=%b", j, obs, ex);
      end
      if (j == 40) begin
        QUOC = 8'h55; RESTO_VAL = 8'h66; LOAD = 1'b1; CLEAR = 1'b1;
      end
      if (j == 41) begin
        LOAD = 1'b0; CLEAR = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs, ex;
    logic pg;
    int jj;
    do_load(3'b011, 8'h3A, 8'h05, 1'b1);
    for (int j = 1; j <= 81; j++) begin
      step();
      if (j <= 41) begin
        pg = (j >= 33);
        ex = exp_out(cyc, pg ? 8'h05 : 8'h3A, 1'b1, pg, 1'b0);
      end else begin
        jj = j - 41;
        pg = (jj >= 33);
        ex = exp_out(cyc, pg ? 8'h09 : 8'h12, 1'b1, pg, 1'b0);
      end
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL back_to_back j=%0d got=%b exp=%b", j, obs, ex);
      end
      if (j == 40) begin
        QUOC = 8'h12; RESTO_VAL = 8'h09; RESTO = 1'b1; SEL = 3'b011; LOAD = 1'b1;
      end
      if (j == 41) LOAD = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] obs, ex;
    logic pg;
    do_load(3'b011, 8'h3A, 8'h05, 1'b1);
    repeat (40) step();
    #2 RST = 1'b1;
    #1;
    obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
    n_cmp++;
    if (obs !== 8'b11_0000_0_0) begin
      n_bad++;
      $display("FAIL reset_mid_async got=%b exp=%b", obs, 8'b11_0000_0_0);
    end
    for (int j = 0; j < 3; j++) begin
      step();
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== 8'b11_0000_0_0) begin
        n_bad++;
        $display("FAIL reset_mid_hold j=%0d got=%b exp=%b", j, obs, 8'b11_0000_0_0);
      end
    end
    RST = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== 8'b11_0000_0_0) begin
        n_bad++;
        $display("FAIL reset_mid_after j=%0d got=%b exp=%b", j, obs, 8'b11_0000_0_0);
      end
    end
    do_load(3'b011, 8'hB7, 8'h4E, 1'b1);
    for (int j = 1; j <= 36; j++) begin
      step();
      pg  = (j >= 33);
      ex  = exp_out(cyc, pg ? 8'h4E : 8'hB7, 1'b1, pg, 1'b0);
      obs = {DIG_EN, NIBBLE, LED_RESTO, PAGE};
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL reset_mid_reload j=%0d got=%b exp=%b", j, obs, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_no_remainder();
    test_other_op();
    test_clear_vs_load();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
